// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, synchronous read-before-write, reset only on the read register.
module sdp_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wa,
   input  logic [WIDTH-1:0]         wd,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] ra,
   output logic [WIDTH-1:0]         rd
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   // read register holds between enables, so it doubles as the held output
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rd <= '0;
      else if (re) rd <= mem[ra];
endmodule

// File: rtl/sample_delay.sv
// sample_delay: runtime-programmable delay line counted in accepted samples,
// gated by a fill counter so stale or uninitialised entries never reach dout.
module sample_delay #(
   parameter int WIDTH   = 8,
   parameter int MAX_DEL = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic [$clog2(MAX_DEL+1)-1:0] del,
   input  logic                         din_vld,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         dout_vld,
   output logic                         filled
);
   localparam int AW = $clog2(MAX_DEL);
   localparam int DW = $clog2(MAX_DEL + 1);
   localparam logic [DW-1:0] MAXD = DW'(MAX_DEL);
   logic [AW-1:0] wp, ra;
   logic [DW-1:0] fill, fill_n, del_r, del_q;
   logic chg, acc, fire;
   function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d);
      return d == '0 ? DW'(1) : d > MAXD ? MAXD : d;
   endfunction
   // a flush or delay change drops the sample on that cycle and restarts the fill
   always_comb begin
      del_q  = clamp(del_r);
      chg    = del != del_r;
      acc    = din_vld && !clr && !chg;
      fire   = acc && fill >= del_q;
      fill_n = (clr || chg) ? '0 : (acc && fill != MAXD) ? fill + DW'(1) : fill;
      ra     = wp - del_q[AW-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp       <= '0;
         fill     <= '0;
         del_r    <= DW'(1);
         dout_vld <= 1'b0;
         filled   <= 1'b0;
      end else begin
         wp       <= wp + AW'(acc);
         fill     <= fill_n;
         del_r    <= del;
         dout_vld <= fire;
         filled   <= fill_n >= clamp(del);
      end
   sdp_ram #(.WIDTH(WIDTH), .DEPTH(MAX_DEL)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (acc),
      .wa    (wp),
      .wd    (din),
      .re    (fire),
      .ra    (ra),
      .rd    (dout)
   );
endmodule

// File: doc/sample_delay.md
# sample_delay

Runtime-programmable, sample-counted delay line, the read-back counterpart to the fixed, cycle-counted delay shift register. A write side stores each valid input sample into a circular buffer. A read side returns the sample written `del` samples earlier. The block sits in strobed datapaths, such as pixel, tick and game-step pipelines, where the pipeline stalls and the delay must follow samples rather than clock cycles.

## Interface
- `WIDTH`, 8, data bit width
- `MAX_DEL`, 16, maximum delay in samples; must be a power of 2 and at least 2
- `clk`  in  1  posedge clock; the only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous flush: empties the buffer; `del` is unaffected
- `del`  in  clog2(MAX_DEL+1)  requested delay in samples
- `din_vld`  in  1  sample strobe; `din` is accepted on every cycle this is high
- `din`  in  WIDTH  input sample
- `dout`  out  WIDTH  delayed sample; registered; holds its value between strobes
- `dout_vld`  out  1  one-cycle pulse when `dout` carries a valid delayed sample
- `filled`  out  1  high once the buffer holds at least `del_q` samples

## Operation
- **Delay clamp:** `del_q` is the effective delay, equal to `del` clamped to the range 1..MAX_DEL. A value of 0 is treated as 1.
- **Write side:** on each accepted sample, write `mem[wp] <= din` and increment `wp`, wrapping modulo MAX_DEL.
- **Read side:** in the same cycle, read `mem[(wp - del_q) mod MAX_DEL]`.
  - When `del_q == MAX_DEL` the read and write addresses collide. The read must return the old contents (read-before-write).
- **Fill counter:** `fill` increments on each accepted sample and saturates at MAX_DEL.
  - Define `full_hit = (fill >= del_q)`, evaluated before the increment.
  - `dout` and `dout_vld` update only on cycles where `din_vld` and `full_hit` are both true.
- **Delay change:** `del` is compared every cycle against the registered request.
  - If it differs, the block latches the new `del_q`, clears `fill` to 0 and suppresses `dout_vld` on that cycle.
  - The buffer then refills; no stale sample is ever emitted.
- **Flush:** `clr` clears `fill` and suppresses `dout_vld` on that cycle. A sample presented on the same cycle is dropped. `wp` is kept.
- **Priority:** `clr` is applied first, then a delay change, then normal operation.
- **Memory:** `mem` is not reset. Outputs are gated by `fill`, so uninitialised entries are never seen.

## Timing
- **Reset values:**
  - `dout = 0`, `dout_vld = 0`, `filled = 0`
  - `wp = 0`, `fill = 0`, `del_q = 1`
  - The registered request also resets to 1.
- **Latency:** sample n appears on `dout` one clock after the rising edge that accepts sample n+del_q.
  - The delay is counted in samples. Idle cycles between strobes do not advance the delay.
- **`dout_vld` behaviour:** high for exactly one cycle per qualifying strobe. With a continuous `din_vld`, the first pulse follows the (del_q+1)-th accepted sample.
- **`filled`:** a registered copy of `fill >= del_q`. It drops on the cycle after a `clr` or a delay change.
- **Reset mid-stream:** asserting `rst_n` low clears all state immediately. The first `dout_vld` after release again requires del_q+1 samples.

## Structure
- **No shared package.** The only derived constants are `AW = clog2(MAX_DEL)` and `DW = clog2(MAX_DEL+1)`, both local.
- **Sub-module `sdp_ram`:**
  - Simple dual-port: one write port and one read port.
  - Parameters `WIDTH` and `DEPTH`.
  - Synchronous read with read-before-write behaviour.
  - Kept separate so it can map to block RAM.
- **Top level:** contains the pointer, fill counter, clamp, change detection and output registers.

## Test plan
- **Nominal:** `del = 3`, continuous `din_vld`, `din = 1, 2, 3, …`.
  - Expect the first `dout_vld` one cycle after `din = 4` is accepted, with `dout = 1`.
  - Then `dout = 2, 3, …` every cycle.
- **Stalls:** `del = 2`, strobes separated by 0–5 idle cycles.
  - Expect `dout` to always equal the value two strobes earlier.
  - Expect `dout` to hold its value during idle cycles.
- **Boundaries:** `del = 16` with MAX_DEL = 16.
  - Expect the 17th sample to produce `dout = 1`, exercising the read-before-write collision.
  - `del = 0` must behave as 1.
  - `del = 31` (out of range) must behave as 16.
- **Delay change mid-stream:** steady at `del = 2`, then switch to `del = 4`.
  - Expect no `dout_vld` until 5 samples after the change.
  - Expect the first emitted value to be the sample accepted right after the change.
- **Flush and reset:**
  - `clr` asserted together with `din_vld`: that sample is dropped and `filled` goes low the next cycle.
  - Async `rst_n` pulse mid-stream: all outputs read 0 while in reset, and refill starts from scratch.
